// File: rtl/demux6_router.sv
// Registered 1-to-NCH stream distributor: each input beat lands in a one-entry
// holding register for its selected channel; unroutable selects are dropped and counted.
module demux6_router #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NCH   = 6,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]     drop_count,
    output logic                 drop_pulse
);

    logic [NCH-1:0] load_c;
    logic           legal_c;
    logic           drop_c;

    // Select decode; a full channel still accepts when it drains in the same cycle.
    always_comb begin
        legal_c  = 1'b0;
        in_ready = 1'b1;
        load_c   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (in_sel == 3'(i)) begin
                legal_c   = 1'b1;
                in_ready  = !out_valid[i] || out_ready[i];
                load_c[i] = in_valid && (!out_valid[i] || out_ready[i]);
            end
        end
        drop_c = in_valid && !legal_c;
    end

    // Channel holding registers and saturating drop accounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= '0;
            out_data   <= '0;
            drop_count <= '0;
            drop_pulse <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (load_c[i]) begin
                    out_valid[i]                <= 1'b1;
                    out_data[i*WIDTH +: WIDTH]  <= in_data;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
            drop_pulse <= drop_c;
            if (drop_c && (drop_count != '1)) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/demux6_router.md
Name: demux6_router

Overview:
- Registered 1-to-6 stream distributor. It is the counterpart of the team's 6-way data selector: one input stream fans out to six output channels instead of six inputs collapsing to one.
- Each input beat carries a 3-bit destination select and is delivered into a one-entry holding register for that channel.
- Each channel has a valid/ready handshake toward its consumer.
- Selects with no destination channel (6, 7) are dropped and counted, mirroring the selector's default-zero arm.

Parameters:
- WIDTH, 4, data width per beat and per channel.
- NCH, 6, number of output channels; legal range 2..8; select is always 3 bits.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  input beat accepted this cycle when in_valid & in_ready
- in_sel  in  3  destination channel of the beat
- in_data  in  WIDTH  beat payload
- out_valid  out  NCH  bit i: channel i holds a beat
- out_ready  in  NCH  bit i: consumer i takes the beat this cycle
- out_data  out  NCH*WIDTH  channel i payload at [i*WIDTH +: WIDTH]
- drop_count  out  CNT_W  number of beats dropped for an illegal select; saturates
- drop_pulse  out  1  registered 1-cycle strobe, one cycle after each dropped beat

Behaviour:
- Reset (synchronous, active-high, at a clk edge while reset=1):
  - out_valid=0, out_data=0, drop_count=0, drop_pulse=0.
  - Any held beats are discarded; reset has priority over every other event in that cycle.
- in_ready is combinational from the current state and inputs:
  - If in_sel >= NCH: in_ready=1, so illegal beats are always consumed.
  - Otherwise: in_ready = !out_valid[in_sel] | out_ready[in_sel], so a full channel accepts when it drains in the same cycle.
- in_ready does not depend on in_valid.
- Accept with legal select at the edge: out_valid[in_sel]<=1 and data slot <= in_data. The beat is visible on out_data/out_valid one cycle after acceptance (latency 1).
- Channel drain at the edge when out_valid[i] & out_ready[i]:
  - Not reloaded that cycle: out_valid[i]<=0; out_data slot holds its last value.
  - Same-cycle drain and reload: out_valid[i] stays 1 and the new data replaces the old. No bubble, no loss, no duplication.
- out_ready[i] while out_valid[i]=0: no effect.
- Channels are independent; any number of channels may drain in the same cycle. At most one channel loads per cycle.
- Full channel, no drain, in_valid=1 to it: in_ready=0. The source holds in_valid, in_sel and in_data; held channel contents are unchanged.
- Illegal select accept (in_sel >= NCH, in_valid=1):
  - No channel changes.
  - drop_count <= drop_count+1, saturating at all-ones; no wrap.
  - drop_pulse<=1 for the following cycle; otherwise drop_pulse<=0.
- in_valid=0: no state change other than channel drains; in_sel and in_data are don't-care.
- No X-propagation: out_data of an empty channel is the last delivered value, or 0 since reset.

Test Plan:
- Reset, then send sel=0..5 with data 4'h1..4'h6 on consecutive cycles, all out_ready=1 -> each out_valid[i] pulses for exactly 1 cycle, one cycle after its accept; slot i reads i+1; drop_count=0.
- out_ready=0; send sel=2 data 4'hA, then sel=2 data 4'hB -> first accepted; second sees in_ready=0 and is held. Raise out_ready[2] -> 4'hA drains and 4'hB loads the same cycle; out_valid[2] stays 1; next cycle slot 2 =4'hB.
- Send sel=6 data 4'hF, then sel=7 -> in_ready=1 both cycles; no out_valid change; drop_pulse high on the two following cycles; drop_count=2.
- 260 consecutive illegal beats after reset -> drop_count saturates at 8'hFF; no wrap to 0.
- Fill channels 1 and 4 (out_ready=0), assert reset for one edge -> out_valid=0, out_data=0, drop_count=0. A sel=1 beat the cycle after reset is accepted normally.
- Random traffic, 2000 cycles, random out_ready -> per-channel scoreboard: every accepted legal beat delivered exactly once, in order; drop_count equals the illegal-accept count.
